round_robin_tabla_pesos: RTL and testbench
==========================================

// Module: round_robin_tabla_pesos
// PURPOSE
//  Table-driven weighted round-robin arbiter over QUEUE_QUANTITY FIFO queues.
//  Walks a TABLE_SIZE-entry arbitration table of {queue, weight} entries.
//  Grants the entry's queue up to `weight` consumed words, then advances to the next entry.
//  Sits between the FIFO bank (buf_empty) and the output mux / pop logic (selector, pop).
// PARAMETERS
//  QUEUE_QUANTITY  4   number of FIFO queues; SW = $clog2(QUEUE_QUANTITY)
//  MAX_WEIGHT      64  weight range; WW = $clog2(MAX_WEIGHT); weights 0..MAX_WEIGHT-1
//  TABLE_SIZE      8   arbitration table entries; PW = $clog2(TABLE_SIZE)
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              asynchronous, active-low reset
//  enb          in   1              global enable; 0 freezes state and forces selector_enb=0
//  cfg_load     in   1              pulse: latch pesos/selecciones, restart at entry 0
//  pesos        in   TABLE_SIZE*WW  weight of entry k at [(k+1)*WW-1 : k*WW]
//  selecciones  in   TABLE_SIZE*SW  queue of entry k at [(k+1)*SW-1 : k*SW]
//  buf_empty    in   QUEUE_QUANTITY per-queue FIFO empty flag
//  pop          in   1              consumer took the word on selector this cycle
//  selector     out  SW             granted queue index
//  selector_enb out  1              grant valid
//  tabla_idx    out  PW             current table pointer
//  credito      out  WW             words remaining for current entry
// BEHAVIOUR
//  Reset: state=IDLE, tabla_idx=0, credito=0, selector=0, selector_enb=0, shadow tables cleared.
//  FSM:
//   IDLE     -> CARGA when enb=1.
//   CARGA    -> SERVICIO; latches pesos/selecciones into shadow regs.
//               Sets ptr = first entry >=0 with weight!=0; credito = its weight.
//               If all weights are 0: remains in CARGA, selector_enb=0.
//   SERVICIO -> CARGA on cfg_load (any state except IDLE; cfg_load wins over pop).
//  Grant (SERVICIO, enb=1): selector = shadow_sel[ptr], combinational from registered ptr.
//   selector_enb = !buf_empty[selector]; zero-latency response to buf_empty.
//  pop counts only when selector_enb=1; pop with selector_enb=0 is ignored.
//  Counted pop, credito>1: credito -= 1.
//  Counted pop, credito==1: advance to the next entry with weight!=0.
//   Search order ptr+1 .. TABLE_SIZE-1, then wrap to 0.
//   Load credito with that entry's weight.
//   A single nonzero entry re-loads itself.
//  Empty current queue (selector_enb=0):
//   Next cycle, advance exactly as above; remaining credit is forfeited.
//   Costs one bubble cycle per skipped entry.
//  Weight 0 entries are never selected.
//  Shadow table changes only in CARGA; input changes without cfg_load have no effect.
//  enb=0: all registers hold, selector_enb=0, pops ignored.
//  Reset mid-operation: immediate return to reset values; table must reload via CARGA.
//  Arithmetic: ptr wraps modulo TABLE_SIZE (non-power-of-2 handled explicitly); credito never underflows.
// CONFIGURATION
//  RR_TABLA_LOOKAHEAD_EN:
//   Defined: work-conserving, no bubble on empty or zero-weight entries.
//    Combinational scan ptr..ptr+TABLE_SIZE-1 (wrapping) finds the first entry
//    with weight!=0 and a non-empty queue; selector and selector_enb come from it the same cycle.
//    A counted pop on a scanned entry sets ptr to it, with credito = its weight-1
//    (advance if weight==1).
//    selector_enb=0 only when every weighted entry's queue is empty; ptr then holds.
//   Undefined: bubble/forfeit behaviour above.
// TESTING
//  T1 table sel=[1,3,2,0..] w=[3,2,1,0..], all queues non-empty, pop=1 every cycle
//     -> selector 1,1,1,3,3,2,1,1,1,... with selector_enb=1 continuously.
//  T2 T1 table, buf_empty[3]=1
//     -> 1,1,1, then one cycle selector_enb=0 (selector=3), then 2,1,1,1.
//     With RR_TABLA_LOOKAHEAD_EN: 1,1,1,2,1,... with no gap.
//  T3 all weights 0, cfg_load
//     -> selector_enb stays 0, FSM stays in CARGA, tabla_idx=0.
//  T4 pop held 1 while buf_empty[selector]=1
//     -> credito unchanged by the pops; pointer advance only via skip rule.
//  T5 cfg_load and pop in the same cycle, mid-entry (credito=2)
//     -> next cycle CARGA; then tabla_idx=first nonzero entry with full credit.
//  T6 rst low asynchronously mid-SERVICIO (between edges)
//     -> outputs 0 immediately.
//     After release: IDLE, then CARGA, then sequence restarts from entry 0.

Source files
------------

// File: rtl/round_robin_tabla_pesos.sv
// Table-driven weighted round-robin arbiter: walks a {queue, weight} table, granting each queue up to weight pops.
// Optional RR_TABLA_LOOKAHEAD_EN makes the walk work-conserving (no bubbles on empty queues).
module round_robin_tabla_pesos #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int MAX_WEIGHT     = 64,
   parameter int TABLE_SIZE     = 8,
   localparam int SW = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1,
   localparam int WW = (MAX_WEIGHT > 1) ? $clog2(MAX_WEIGHT) : 1,
   localparam int PW = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enb,
   input  logic                     cfg_load,
   input  logic [TABLE_SIZE*WW-1:0] pesos,
   input  logic [TABLE_SIZE*SW-1:0] selecciones,
   input  logic [QUEUE_QUANTITY-1:0] buf_empty,
   input  logic                     pop,
   output logic [SW-1:0]            selector,
   output logic                     selector_enb,
   output logic [PW-1:0]            tabla_idx,
   output logic [WW-1:0]            credito
);

   typedef enum logic [1:0] {IDLE, CARGA, SERVICIO} state_t;

   state_t        state_reg;
   logic [PW-1:0] ptr_reg;
   logic [WW-1:0] credito_reg;
   logic [WW-1:0] shadow_w_reg [TABLE_SIZE];
   logic [SW-1:0] shadow_s_reg [TABLE_SIZE];

   logic [WW-1:0] pesos_arr [TABLE_SIZE];
   logic [SW-1:0] sel_arr   [TABLE_SIZE];

   logic          carga_found;
   logic [PW-1:0] carga_idx;
   logic          scan_found;
   logic [PW-1:0] scan_idx;
   logic [PW-1:0] adv_idx;
   logic [WW-1:0] eff_credit;

   generate
      for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_unpack
         assign pesos_arr[gi] = pesos[gi*WW +: WW];
         assign sel_arr[gi]   = selecciones[gi*SW +: SW];
      end
   endgenerate

   // First nonzero entry of the incoming table, scanned from entry 0.
   always_comb begin
      carga_found = 1'b0;
      carga_idx   = '0;
      for (int k = TABLE_SIZE - 1; k >= 0; k--) begin
         if (pesos_arr[k] != '0) begin
            carga_found = 1'b1;
            carga_idx   = PW'(k);
         end
      end
   end

`ifdef RR_TABLA_LOOKAHEAD_EN
   // First weighted entry with a non-empty queue, starting at ptr and wrapping.
   always_comb begin
      int            j;
      logic [PW-1:0] jj;
      j          = 0;
      jj         = '0;
      scan_found = 1'b0;
      scan_idx   = ptr_reg;
      for (int k = TABLE_SIZE - 1; k >= 0; k--) begin
         j = int'(ptr_reg) + k;
         if (j >= TABLE_SIZE) j = j - TABLE_SIZE;
         jj = PW'(j);
         if (shadow_w_reg[jj] != '0 && !buf_empty[shadow_s_reg[jj]]) begin
            scan_found = 1'b1;
            scan_idx   = jj;
         end
      end
   end
`else
   assign scan_found = !buf_empty[shadow_s_reg[ptr_reg]];
   assign scan_idx   = ptr_reg;
`endif

   // Next nonzero entry after scan_idx; offset TABLE_SIZE lands on scan_idx itself.
   always_comb begin
      int            j;
      logic [PW-1:0] jj;
      j       = 0;
      jj      = '0;
      adv_idx = scan_idx;
      for (int k = TABLE_SIZE; k >= 1; k--) begin
         j = int'(scan_idx) + k;
         if (j >= TABLE_SIZE) j = j - TABLE_SIZE;
         jj = PW'(j);
         if (shadow_w_reg[jj] != '0) adv_idx = jj;
      end
   end

   assign eff_credit = (scan_idx == ptr_reg) ? credito_reg : shadow_w_reg[scan_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         ptr_reg     <= '0;
         credito_reg <= '0;
         for (int k = 0; k < TABLE_SIZE; k++) begin
            shadow_w_reg[k] <= '0;
            shadow_s_reg[k] <= '0;
         end
      end else if (enb) begin
         case (state_reg)
            IDLE: state_reg <= CARGA;
            CARGA: begin
               for (int k = 0; k < TABLE_SIZE; k++) begin
                  shadow_w_reg[k] <= pesos_arr[k];
                  shadow_s_reg[k] <= sel_arr[k];
               end
               if (carga_found) begin
                  state_reg   <= SERVICIO;
                  ptr_reg     <= carga_idx;
                  credito_reg <= pesos_arr[carga_idx];
               end else begin
                  ptr_reg     <= '0;
                  credito_reg <= '0;
               end
            end
            SERVICIO: begin
               if (cfg_load) begin
                  state_reg <= CARGA;
               end else if (scan_found && pop) begin
                  if (eff_credit > WW'(1)) begin
                     ptr_reg     <= scan_idx;
                     credito_reg <= eff_credit - WW'(1);
                  end else begin
                     ptr_reg     <= adv_idx;
                     credito_reg <= shadow_w_reg[adv_idx];
                  end
               end
`ifndef RR_TABLA_LOOKAHEAD_EN
               else if (!scan_found) begin
                  // Empty queue: drop remaining credit and move on.
                  ptr_reg     <= adv_idx;
                  credito_reg <= shadow_w_reg[adv_idx];
               end
`endif
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign selector     = (state_reg == SERVICIO) ? shadow_s_reg[scan_idx] : '0;
   assign selector_enb = enb && (state_reg == SERVICIO) && scan_found;
   assign tabla_idx    = ptr_reg;
   assign credito      = credito_reg;

endmodule

// File: tb/tb_round_robin_tabla_pesos.sv
// Scoreboard bench for round_robin_tabla_pesos: directed table scenarios, grants checked by a negedge monitor.
module tb_round_robin_tabla_pesos;

   logic        clk = 1'b0;
   logic        rst;
   logic        enb;
   logic        cfg_load;
   logic [47:0] pesos;
   logic [15:0] selecciones;
   logic [3:0]  buf_empty;
   logic        pop;
   logic [1:0]  selector;
   logic        selector_enb;
   logic [2:0]  tabla_idx;
   logic [5:0]  credito;

   typedef struct packed {
      logic       en;
      logic [1:0] sel;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   round_robin_tabla_pesos dut (
      .clk(clk), .rst(rst), .enb(enb), .cfg_load(cfg_load),
      .pesos(pesos), .selecciones(selecciones), .buf_empty(buf_empty), .pop(pop),
      .selector(selector), .selector_enb(selector_enb),
      .tabla_idx(tabla_idx), .credito(credito)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic en, input logic [1:0] sel);
      exp_t e;
      e.en  = en;
      e.sel = sel;
      exp_q.push_back(e);
   endtask

   task automatic load_tab(input logic [1:0] s0, s1, s2, input logic [5:0] w0, w1, w2);
      pesos              = '0;
      selecciones        = '0;
      pesos[5:0]         = w0;
      pesos[11:6]        = w1;
      pesos[17:12]       = w2;
      selecciones[1:0]   = s0;
      selecciones[3:2]   = s1;
      selecciones[5:4]   = s2;
   endtask

   task automatic reload();
      cfg_load = 1'b1;
      cyc(1);
      cfg_load = 1'b0;
      cyc(1);
   endtask

   // Monitor: every cycle the consumer offers a pop is one transaction.
   always @(negedge clk) begin
      if (rst && enb && pop) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_txn: got sel=%0d en=%0d expected none", selector, selector_enb);
         end else begin
            mon_e = exp_q.pop_front();
            if (selector_enb !== mon_e.en || selector !== mon_e.sel) begin
               errors++;
               $display("FAIL grant: got sel=%0d en=%0d expected sel=%0d en=%0d",
                        selector, selector_enb, mon_e.sel, mon_e.en);
            end else begin
               $display("txn sel=%0d en=%0d", selector, selector_enb);
            end
         end
      end
   end

   initial begin
      rst = 1'b0; enb = 1'b0; cfg_load = 1'b0; pop = 1'b0; buf_empty = 4'b0000;
      load_tab(2'd1, 2'd3, 2'd2, 6'd3, 6'd2, 6'd1);
      #3;
      check("rst_enb", selector_enb, 0);
      check("rst_sel", selector, 0);
      check("rst_idx", tabla_idx, 0);
      check("rst_cred", credito, 0);
      cyc(1);
      rst = 1'b1; enb = 1'b1;

      // T1: IDLE -> CARGA -> SERVICIO, then full weighted sequence
      cyc(2);
      check("t1_idx0", tabla_idx, 0);
      check("t1_cred0", credito, 3);
      push(1,1); push(1,1); push(1,1); push(1,3); push(1,3);
      push(1,2); push(1,1); push(1,1); push(1,1); push(1,3);
      pop = 1'b1; cyc(10); pop = 1'b0;
      check("t1_idx_end", tabla_idx, 1);
      check("t1_cred_end", credito, 1);

      // T2: queue 3 empty
      buf_empty = 4'b1000;
      reload();
      check("t2_idx0", tabla_idx, 0);
      check("t2_cred0", credito, 3);
`ifdef RR_TABLA_LOOKAHEAD_EN
      push(1,1); push(1,1); push(1,1); push(1,2);
      push(1,1); push(1,1); push(1,1); push(1,2);
      pop = 1'b1; cyc(8); pop = 1'b0;
      check("t2_idx_end", tabla_idx, 0);
      check("t2_cred_end", credito, 3);
`else
      push(1,1); push(1,1); push(1,1); push(0,3);
      push(1,2); push(1,1); push(1,1); push(1,1);
      pop = 1'b1; cyc(8); pop = 1'b0;
      check("t2_idx_end", tabla_idx, 1);
      check("t2_cred_end", credito, 2);

      // T4: pops against an empty queue do not spend credit
      load_tab(2'd3, 2'd1, 2'd0, 6'd5, 6'd2, 6'd0);
      reload();
      check("t4_idx0", tabla_idx, 0);
      check("t4_cred0", credito, 5);
      push(0,3); push(1,1); push(1,1); push(0,3);
      pop = 1'b1; cyc(4); pop = 1'b0;
      check("t4_idx_end", tabla_idx, 1);
      check("t4_cred_end", credito, 2);
`endif

      // T5: cfg_load and pop together mid-entry
      buf_empty = 4'b0000;
      load_tab(2'd1, 2'd3, 2'd2, 6'd3, 6'd2, 6'd1);
      reload();
      push(1,1);
      pop = 1'b1; cyc(1);
      check("t5_cred_mid", credito, 2);
      load_tab(2'd1, 2'd3, 2'd2, 6'd0, 6'd4, 6'd1);
      cfg_load = 1'b1;
      push(1,1);
      cyc(1);
      cfg_load = 1'b0; pop = 1'b0;
      check("t5_carga_enb", selector_enb, 0);
      cyc(1);
      check("t5_idx", tabla_idx, 1);
      check("t5_cred", credito, 4);

      // Input table changes without cfg_load are ignored
      load_tab(2'd1, 2'd3, 2'd2, 6'd3, 6'd2, 6'd1);
      push(1,3); push(1,3);
      pop = 1'b1; cyc(2); pop = 1'b0;
      check("shadow_idx", tabla_idx, 1);
      check("shadow_cred", credito, 2);

      // enb=0 freezes state and drops grants
      enb = 1'b0; pop = 1'b1;
      cyc(1);
      check("frz_enb", selector_enb, 0);
      cyc(2);
      check("frz_idx", tabla_idx, 1);
      check("frz_cred", credito, 2);
      enb = 1'b1; pop = 1'b0;

      // T3: all weights zero
      load_tab(2'd1, 2'd3, 2'd2, 6'd0, 6'd0, 6'd0);
      cfg_load = 1'b1; cyc(1); cfg_load = 1'b0;
      cyc(3);
      check("t3_enb", selector_enb, 0);
      check("t3_idx", tabla_idx, 0);

      // T6: async reset mid-service
      load_tab(2'd1, 2'd3, 2'd2, 6'd3, 6'd2, 6'd1);
      reload();
      push(1,1); push(1,1); push(1,1); push(1,3);
      pop = 1'b1; cyc(4); pop = 1'b0;
      check("t6_pre_idx", tabla_idx, 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("t6_rst_enb", selector_enb, 0);
      check("t6_rst_sel", selector, 0);
      check("t6_rst_idx", tabla_idx, 0);
      check("t6_rst_cred", credito, 0);
      cyc(1);
      rst = 1'b1;
      cyc(1);
      check("t6_carga_enb", selector_enb, 0);
      cyc(1);
      check("t6_idx", tabla_idx, 0);
      check("t6_cred", credito, 3);
      push(1,1); push(1,1); push(1,1); push(1,3);
      pop = 1'b1; cyc(4); pop = 1'b0;

      cyc(1);
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
